// File: rtl/demux_router.sv
// demux_router: 1-to-2 stream demultiplexer with valid/ready handshake.
// A beat is steered by i_sel (1 -> channel A, 0 -> channel B) into that
// channel's 2-entry data FIFO; each channel keeps a saturating beat counter.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_data, i_sel, i_valid   input beat, route select, beat valid
//   o_ready                  input accepted when i_valid & o_ready
//   o_a, o_a_valid, i_a_ready  channel A output stream
//   o_b, o_b_valid, i_b_ready  channel B output stream
//   i_clr_cnt                synchronous clear of both counters
//   o_cnt_a, o_cnt_b         saturating counts of beats routed per channel
//
// Optional build macro: DEMUX_ROUTER_ASSERT_EN adds immediate protocol checks
// to the clocked process; behaviour is identical with or without it.
module demux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_a,
  output logic             o_a_valid,
  input  logic             i_a_ready,
  output logic [WIDTH-1:0] o_b,
  output logic             o_b_valid,
  input  logic             i_b_ready,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  // Channel index 0 is A, 1 is B.
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [WIDTH-1:0] mem_d    [NCH][DEPTH];
  logic             wr_ptr_q [NCH];
  logic             wr_ptr_d [NCH];
  logic             rd_ptr_q [NCH];
  logic             rd_ptr_d [NCH];
  logic [OCC_W-1:0] occ_q    [NCH];
  logic [OCC_W-1:0] occ_d    [NCH];
  logic [WIDTH-1:0] head_q   [NCH];
  logic [WIDTH-1:0] head_d   [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [NCH-1:0]   valid_q;
  logic [NCH-1:0]   valid_d;

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   cons_rdy;

  // Ready depends only on the selected channel's registered occupancy.
  assign full[0]  = (occ_q[0] == OCC_FULL);
  assign full[1]  = (occ_q[1] == OCC_FULL);
  assign o_ready  = i_sel ? ~full[0] : ~full[1];

  assign push[0]  = i_valid & o_ready & i_sel;
  assign push[1]  = i_valid & o_ready & ~i_sel;
  assign cons_rdy = {i_b_ready, i_a_ready};
  assign pop      = valid_q & cons_rdy;

  assign o_a       = head_q[0];
  assign o_a_valid = valid_q[0];
  assign o_b       = head_q[1];
  assign o_b_valid = valid_q[1];
  assign o_cnt_a   = cnt_q[0];
  assign o_cnt_b   = cnt_q[1];

  // Next-state for both FIFOs, their registered head/valid and counters.
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      mem_d[ch]    = mem_q[ch];
      wr_ptr_d[ch] = wr_ptr_q[ch];
      rd_ptr_d[ch] = rd_ptr_q[ch];
      occ_d[ch]    = occ_q[ch];
      cnt_d[ch]    = cnt_q[ch];

      if (push[ch]) begin
        mem_d[ch][wr_ptr_q[ch]] = i_data;
        wr_ptr_d[ch]            = ~wr_ptr_q[ch];
      end
      if (pop[ch]) begin
        rd_ptr_d[ch] = ~rd_ptr_q[ch];
      end

      case ({push[ch], pop[ch]})
        2'b10:   occ_d[ch] = occ_q[ch] + OCC_W'(1);
        2'b01:   occ_d[ch] = occ_q[ch] - OCC_W'(1);
        default: occ_d[ch] = occ_q[ch];
      endcase

      // Head is looked up from next-state so the output flop shows it one cycle later.
      head_d[ch]  = mem_d[ch][rd_ptr_d[ch]];
      valid_d[ch] = (occ_d[ch] != '0);

      // Clear wins over a same-cycle push.
      if (i_clr_cnt) begin
        cnt_d[ch] = '0;
      end else if (push[ch] && (cnt_q[ch] != CNT_MAX)) begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // State registers; reset flushes both FIFOs and counters asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          mem_q[ch][e] <= '0;
        end
        wr_ptr_q[ch] <= 1'b0;
        rd_ptr_q[ch] <= 1'b0;
        occ_q[ch]    <= '0;
        head_q[ch]   <= '0;
        cnt_q[ch]    <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        mem_q[ch]    <= mem_d[ch];
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        occ_q[ch]    <= occ_d[ch];
        head_q[ch]   <= head_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
      end
      valid_q <= valid_d;
`ifdef DEMUX_ROUTER_ASSERT_EN
      if (i_valid && $isunknown(i_sel)) begin
        $error("demux_router: i_sel is X/Z while i_valid is high");
      end
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (push[ch] && full[ch]) begin
          $error("demux_router: push into full FIFO on channel %0d", ch);
        end
        if (valid_q[ch] && !cons_rdy[ch] && (head_d[ch] != head_q[ch])) begin
          $error("demux_router: output data changed while stalled on channel %0d", ch);
        end
        if (occ_q[ch] > OCC_FULL) begin
          $error("demux_router: occupancy overflow on channel %0d", ch);
        end
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: a driver issues beats and pushes each
// accepted beat into a per-channel expectation queue; a monitor compares the
// DUT outputs against the queue heads and retires them on each consumer pop.
module tb_demux_router;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_sel = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] o_a;
  logic             o_a_valid;
  logic             i_a_ready = 1'b0;
  logic [WIDTH-1:0] o_b;
  logic             o_b_valid;
  logic             i_b_ready = 1'b0;
  logic             i_clr_cnt = 1'b0;
  logic [CNT_W-1:0] o_cnt_a;
  logic [CNT_W-1:0] o_cnt_b;

  demux_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_sel     (i_sel),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_a       (o_a),
    .o_a_valid (o_a_valid),
    .i_a_ready (i_a_ready),
    .o_b       (o_b),
    .o_b_valid (o_b_valid),
    .i_b_ready (i_b_ready),
    .i_clr_cnt (i_clr_cnt),
    .o_cnt_a   (o_cnt_a),
    .o_cnt_b   (o_cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: queues hold beats accepted but not yet consumed.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check ready/counters mid-cycle, update model at posedge.
  task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic ar, input logic br, input logic clr);
    bit exp_rdy;
    bit acc;
    @(negedge clk);
    i_valid = v; i_sel = s; i_data = d;
    i_a_ready = ar; i_b_ready = br; i_clr_cnt = clr;
    #2;
    exp_rdy = s ? (qa.size() < 2) : (qb.size() < 2);
    check("o_ready", 32'(o_ready), 32'(exp_rdy));
    check("o_cnt_a", 32'(o_cnt_a), 32'(cnt_a));
    check("o_cnt_b", 32'(o_cnt_b), 32'(cnt_b));
    acc = v && exp_rdy;
    @(posedge clk);
    if (i_rst_n) begin
      if (acc) begin
        if (s) qa.push_back(d);
        else   qb.push_back(d);
      end
      if (clr) begin
        cnt_a = 0;
        cnt_b = 0;
      end else if (acc) begin
        if (s) cnt_a = (cnt_a < CNT_SAT) ? cnt_a + 1 : CNT_SAT;
        else   cnt_b = (cnt_b < CNT_SAT) ? cnt_b + 1 : CNT_SAT;
      end
    end
  endtask

  // Asynchronous reset mid-cycle with an immediate (pre-edge) check.
  task automatic async_reset();
    @(negedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("rst_a_valid", 32'(o_a_valid), 32'd0);
    check("rst_b_valid", 32'(o_b_valid), 32'd0);
    check("rst_cnt_a", 32'(o_cnt_a), 32'd0);
    check("rst_cnt_b", 32'(o_cnt_b), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // Monitor: compare outputs to queue heads; retire a beat on each pop.
  initial begin
    bit pop_a;
    bit pop_b;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      check("o_a_valid", 32'(o_a_valid), 32'(qa.size() != 0));
      check("o_b_valid", 32'(o_b_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) check("o_a_data", 32'(o_a), 32'(qa[0]));
      if (qb.size() != 0) check("o_b_data", 32'(o_b), 32'(qb[0]));
      pop_a = (qa.size() != 0) && i_a_ready;
      pop_b = (qb.size() != 0) && i_b_ready;
      @(posedge clk);
      if (i_rst_n) begin
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
      end
    end
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_a", 32'(o_a), 32'd0);
    check("reset_o_b", 32'(o_b), 32'd0);
    check("reset_a_valid", 32'(o_a_valid), 32'd0);
    check("reset_b_valid", 32'(o_b_valid), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Three beats to channel A with consumer ready.
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Channel B stalled: two accepted, third waits until one cycle after the first pop.
    cycle(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Channel A full and stalled must not block a beat for B.
    cycle(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Saturate counter A, then clear in the same cycle as a push.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Two beats buffered per channel, then asynchronous reset.
    cycle(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hE2, 1'b0, 1'b0, 1'b0);
    async_reset();

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 699) begin
        async_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              8'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      end
    end

    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
